// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order via ping-pong banks.
// Define FFT_REORDER_INDEX_EN to add the registered out_index port.
module fft_out_reorder #(
    parameter int DATA_W = 34,
    parameter int N_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
`ifdef FFT_REORDER_INDEX_EN
    output logic [N_LOG2-1:0] out_index,
`endif
    output logic              ovf
);

    localparam int N = 1 << N_LOG2;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    logic [DATA_W-1:0] mem [2][N];
    logic [1:0]        bank_full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_bank;
    logic              rd_bank;
    logic [N_LOG2-1:0] wr_cnt;
    logic [N_LOG2-1:0] rd_cnt;
    logic              dropping;
    logic              drop_start;
    logic              drop_eff;
    logic              wr_en;
    logic              wr_done;
    logic              load;
    logic              rd_done;
    state_t            state;
    state_t            state_nxt;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] k);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) r[i] = k[N_LOG2-1-i];
        return r;
    endfunction

    always_comb begin
        load     = (state == READ) && (!out_valid || out_ready);
        rd_done  = load && (rd_cnt == '1);
        // A bank being released this cycle counts as free for a new frame
        drop_start = in_valid && (wr_cnt == '0) && bank_full[wr_bank]
                     && !(rd_done && (rd_bank == wr_bank));
        drop_eff = (wr_cnt == '0) ? drop_start : dropping;
        wr_en    = in_valid && !drop_eff;
        wr_done  = wr_en && (wr_cnt == '1);
        full_set = wr_done ? (2'b01 << wr_bank) : 2'b00;
        full_clr = rd_done ? (2'b01 << rd_bank) : 2'b00;
        state_nxt = state;
        unique case (state)
            IDLE: if (bank_full[rd_bank]) state_nxt = READ;
            READ: if (rd_done && !bank_full[!rd_bank]) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_cnt] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            dropping  <= 1'b0;
            ovf       <= 1'b0;
            bank_full <= 2'b00;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
        end else begin
            bank_full <= (bank_full & ~full_clr) | full_set;
            ovf       <= ovf | drop_start;
            if (in_valid) begin
                wr_cnt   <= wr_cnt + 1'b1;
                dropping <= (wr_cnt == '1) ? 1'b0 : drop_eff;
            end
            if (wr_done) wr_bank <= ~wr_bank;
            if (load)    rd_cnt  <= rd_cnt + 1'b1;
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
`ifdef FFT_REORDER_INDEX_EN
            out_index <= '0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_bank][bitrev(rd_cnt)];
            out_first <= (rd_cnt == '0);
            out_last  <= (rd_cnt == '1);
`ifdef FFT_REORDER_INDEX_EN
            out_index <= rd_cnt;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
